// File: rtl/regfile_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_arbiter_pkg
//   Shared definitions for the register-file arbiter:
//     - data / address widths
//     - register-file command codes driven on rf_rw ({rd,wr})
//     - FSM state encoding
//     - the latched per-requester command record
// -----------------------------------------------------------------------------
package regfile_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  // rf_rw codes, bit 1 = read, bit 0 = write
  localparam logic [1:0] RW_NOP = 2'b00;
  localparam logic [1:0] RW_WR  = 2'b01;
  localparam logic [1:0] RW_RD  = 2'b10;
  localparam logic [1:0] RW_RW  = 2'b11;

  // Last address visited by the initialise sweep
  localparam logic [ADDR_W-1:0] INIT_LAST = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2,
    ST_INIT = 2'd3
  } state_e;

  // One requester's command as seen on its input ports
  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] aa;
    logic [ADDR_W-1:0] ba;
    logic [ADDR_W-1:0] da;
    logic [DATA_W-1:0] wd;
  } cmd_t;

  // Map the requester's rd/wr flags onto a bus code
  function automatic logic [1:0] rw_code(input logic rd, input logic wr);
    logic [1:0] code;
    unique case ({rd, wr})
      2'b00:   code = RW_NOP;
      2'b01:   code = RW_WR;
      2'b10:   code = RW_RD;
      default: code = RW_RW;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/regfile_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//   Two-way round-robin grant with a last-served pointer.
//   The grant is combinational from the request vector and the pointer; the
//   pointer only moves when the parent accepts the grant.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset (requester 0 = last served)
//   i_req     in   [1:0] request vector
//   i_accept  in   parent consumed the current grant this cycle
//   o_valid   out  at least one request present
//   o_grant   out  index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic       o_valid,
  output logic       o_grant
);

  logic r_last;

  always_comb begin
    o_valid = |i_req;
    unique case (i_req)
      2'b01:   o_grant = 1'b0;
      2'b10:   o_grant = 1'b1;
      default: o_grant = ~r_last;  // tie: whoever was not served last
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b0;
    end else if (i_accept) begin
      r_last <= o_grant;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_arbiter
//   Shares one register-file port between two requesters and owns a
//   full-file initialise sweep.
//
//   A served access walks IDLE -> CMD -> RESP -> IDLE. The command is on the
//   rf bus for the single CMD cycle; the register file registers its read
//   data, so rf_a/rf_b are valid during RESP and are captured into ra/rb on
//   the edge that leaves RESP, together with the one-cycle ack pulse.
//   The init sweep writes INIT_VALUE to addresses 0..15, one per INIT cycle.
//   An init request raised mid-access is remembered and runs before any
//   further request is granted.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   reqN/rdN/wrN        requester N request (held until ackN) and op flags
//   aaN/baN/daN/wdN     requester N read-A/read-B/write address, write data
//   ackN                one-cycle completion pulse to requester N
//   raN/rbN             read data for requester N, updated with ackN on reads
//   init_start          request a full-file initialise
//   busy                high whenever the FSM is not idle
//   rf_en/rf_rw         register-file strobe and {rd,wr} code
//   rf_da/rf_aa/rf_ba   register-file write / read-A / read-B addresses
//   rf_d                register-file write data
//   rf_a/rf_b           register-file registered read data
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter logic [DATA_W-1:0] INIT_VALUE = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0,
  input  logic              rd0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] aa0,
  input  logic [ADDR_W-1:0] ba0,
  input  logic [ADDR_W-1:0] da0,
  input  logic [DATA_W-1:0] wd0,

  input  logic              req1,
  input  logic              rd1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] aa1,
  input  logic [ADDR_W-1:0] ba1,
  input  logic [ADDR_W-1:0] da1,
  input  logic [DATA_W-1:0] wd1,

  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] ra0,
  output logic [DATA_W-1:0] rb0,
  output logic [DATA_W-1:0] ra1,
  output logic [DATA_W-1:0] rb1,

  input  logic              init_start,
  output logic              busy,

  output logic              rf_en,
  output logic [1:0]        rf_rw,
  output logic [ADDR_W-1:0] rf_da,
  output logic [ADDR_W-1:0] rf_aa,
  output logic [ADDR_W-1:0] rf_ba,
  output logic [DATA_W-1:0] rf_d,
  input  logic [DATA_W-1:0] rf_a,
  input  logic [DATA_W-1:0] rf_b
);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_e            r_state;
  logic              r_init_pend;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_win;      // requester owning the access in flight
  logic              r_rd;       // access in flight returns read data

  logic              r_rf_en;
  logic [1:0]        r_rf_rw;
  logic [ADDR_W-1:0] r_rf_da;
  logic [ADDR_W-1:0] r_rf_aa;
  logic [ADDR_W-1:0] r_rf_ba;
  logic [DATA_W-1:0] r_rf_d;
  logic [1:0]        r_ack;
  logic [DATA_W-1:0] r_ra [2];
  logic [DATA_W-1:0] r_rb [2];
  logic              r_busy;

  // ---------------------------------------------------------------------------
  // Next-state values
  // ---------------------------------------------------------------------------
  state_e            w_next_state;
  logic              w_init_pend;
  logic [ADDR_W-1:0] w_cnt;
  logic              w_win;
  logic              w_rd;

  logic              w_rf_en;
  logic [1:0]        w_rf_rw;
  logic [ADDR_W-1:0] w_rf_da;
  logic [ADDR_W-1:0] w_rf_aa;
  logic [ADDR_W-1:0] w_rf_ba;
  logic [DATA_W-1:0] w_rf_d;
  logic [1:0]        w_ack;
  logic [DATA_W-1:0] w_ra [2];
  logic [DATA_W-1:0] w_rb [2];
  logic              w_busy;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic w_grant_valid;
  logic w_grant;
  logic w_accept;
  cmd_t w_cmd0;
  cmd_t w_cmd1;
  cmd_t w_cmd;

  assign w_cmd0 = {rd0, wr0, aa0, ba0, da0, wd0};
  assign w_cmd1 = {rd1, wr1, aa1, ba1, da1, wd1};
  assign w_cmd  = w_grant ? w_cmd1 : w_cmd0;

  // The pointer only advances when a request actually leaves IDLE for CMD
  assign w_accept = (r_state == ST_IDLE) && (w_next_state == ST_CMD);

  rr_arbiter2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .i_req    ({req1, req0}),
    .i_accept (w_accept),
    .o_valid  (w_grant_valid),
    .o_grant  (w_grant)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        // A pending or fresh init always beats waiting requests
        if (init_start || r_init_pend) begin
          w_next_state = ST_INIT;
        end else if (w_grant_valid) begin
          w_next_state = ST_CMD;
        end
      end
      ST_CMD:  w_next_state = ST_RESP;
      ST_RESP: w_next_state = ST_IDLE;
      ST_INIT: begin
        if (r_cnt == INIT_LAST) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next values of the registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets its hold/idle value before the case statement,
  // so no path through the block leaves one unassigned and no latch appears.
  always_comb begin
    w_init_pend = r_init_pend;
    w_cnt       = r_cnt;
    w_win       = r_win;
    w_rd        = r_rd;
    w_rf_en     = 1'b0;
    w_rf_rw     = RW_NOP;
    w_rf_da     = r_rf_da;
    w_rf_aa     = r_rf_aa;
    w_rf_ba     = r_rf_ba;
    w_rf_d      = r_rf_d;
    w_ack       = 2'b00;
    w_ra        = r_ra;
    w_rb        = r_rb;
    w_busy      = (w_next_state != ST_IDLE);

    // Remember an init request that lands in the middle of an access;
    // requests during INIT itself are dropped.
    if (init_start && ((r_state == ST_CMD) || (r_state == ST_RESP))) begin
      w_init_pend = 1'b1;
    end

    unique case (r_state)
      ST_IDLE: begin
        if (w_next_state == ST_INIT) begin
          w_init_pend = 1'b0;
          w_cnt       = '0;
          w_rf_en     = 1'b1;
          w_rf_rw     = RW_WR;
          w_rf_da     = '0;
          w_rf_d      = INIT_VALUE;
        end else if (w_next_state == ST_CMD) begin
          w_win   = w_grant;
          w_rd    = w_cmd.rd;
          w_rf_en = 1'b1;
          w_rf_rw = rw_code(w_cmd.rd, w_cmd.wr);
          w_rf_aa = w_cmd.aa;
          w_rf_ba = w_cmd.ba;
          w_rf_da = w_cmd.da;
          w_rf_d  = w_cmd.wd;
        end
      end
      ST_CMD: begin
        // Bus drops back to NOP for the response cycle
      end
      ST_RESP: begin
        // rf_a/rf_b hold the registered read of the CMD cycle here; on a
        // simultaneous read/write to the same address this is the old value.
        w_ack[r_win] = 1'b1;
        if (r_rd) begin
          w_ra[r_win] = rf_a;
          w_rb[r_win] = rf_b;
        end
      end
      ST_INIT: begin
        if (r_cnt != INIT_LAST) begin
          w_cnt   = r_cnt + 1'b1;
          w_rf_en = 1'b1;
          w_rf_rw = RW_WR;
          w_rf_da = r_cnt + 1'b1;
          w_rf_d  = INIT_VALUE;
        end else begin
          w_cnt = '0;
        end
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_init_pend <= 1'b0;
      r_cnt       <= '0;
      r_win       <= 1'b0;
      r_rd        <= 1'b0;
      r_rf_en     <= 1'b0;
      r_rf_rw     <= RW_NOP;
      r_rf_da     <= '0;
      r_rf_aa     <= '0;
      r_rf_ba     <= '0;
      r_rf_d      <= '0;
      r_ack       <= 2'b00;
      r_ra[0]     <= '0;
      r_ra[1]     <= '0;
      r_rb[0]     <= '0;
      r_rb[1]     <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_init_pend <= w_init_pend;
      r_cnt       <= w_cnt;
      r_win       <= w_win;
      r_rd        <= w_rd;
      r_rf_en     <= w_rf_en;
      r_rf_rw     <= w_rf_rw;
      r_rf_da     <= w_rf_da;
      r_rf_aa     <= w_rf_aa;
      r_rf_ba     <= w_rf_ba;
      r_rf_d      <= w_rf_d;
      r_ack       <= w_ack;
      r_ra        <= w_ra;
      r_rb        <= w_rb;
      r_busy      <= w_busy;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ack0  = r_ack[0];
  assign ack1  = r_ack[1];
  assign ra0   = r_ra[0];
  assign rb0   = r_rb[0];
  assign ra1   = r_ra[1];
  assign rb1   = r_rb[1];
  assign busy  = r_busy;
  assign rf_en = r_rf_en;
  assign rf_rw = r_rf_rw;
  assign rf_da = r_rf_da;
  assign rf_aa = r_rf_aa;
  assign rf_ba = r_rf_ba;
  assign rf_d  = r_rf_d;

endmodule

// File: tb/tb_regfile_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_arbiter
//   Drives regfile_arbiter against a small behavioural register file and
//   compares every response with a transaction-level model: an array of
//   expected register contents, the last read data per requester and the
//   round-robin rule "with both waiting, the one not served last wins".
// -----------------------------------------------------------------------------
module tb_regfile_arbiter;

  localparam logic [15:0] INIT_VAL = 16'h5A5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  req, rd, wr;
  logic [3:0]  aa [2];
  logic [3:0]  ba [2];
  logic [3:0]  da [2];
  logic [15:0] wd [2];
  logic        init_start;

  logic        ack0, ack1, busy, rf_en;
  logic [15:0] ra0, rb0, ra1, rb1;
  logic [1:0]  rf_rw;
  logic [3:0]  rf_da, rf_aa, rf_ba;
  logic [15:0] rf_d, rf_a, rf_b;

  regfile_arbiter #(.INIT_VALUE(INIT_VAL)) dut (
    .clk(clk), .reset(reset),
    .req0(req[0]), .rd0(rd[0]), .wr0(wr[0]), .aa0(aa[0]), .ba0(ba[0]), .da0(da[0]), .wd0(wd[0]),
    .req1(req[1]), .rd1(rd[1]), .wr1(wr[1]), .aa1(aa[1]), .ba1(ba[1]), .da1(da[1]), .wd1(wd[1]),
    .ack0(ack0), .ack1(ack1), .ra0(ra0), .rb0(rb0), .ra1(ra1), .rb1(rb1),
    .init_start(init_start), .busy(busy),
    .rf_en(rf_en), .rf_rw(rf_rw), .rf_da(rf_da), .rf_aa(rf_aa), .rf_ba(rf_ba), .rf_d(rf_d),
    .rf_a(rf_a), .rf_b(rf_b)
  );

  // Register file attached to the bus: registered read-before-write port
  logic [15:0] rf_mem [16] = '{default: 16'h0000};
  always @(posedge clk) begin
    if (rf_en) begin
      rf_a <= rf_mem[rf_aa];
      rf_b <= rf_mem[rf_ba];
      if (rf_rw[0]) rf_mem[rf_da] <= rf_d;
    end
  end

  // Reference model
  logic [15:0] exp_mem [16];
  logic [15:0] exp_ra [2];
  logic [15:0] exp_rb [2];
  int          last_served;

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic get_ack(input int n);
    return (n == 0) ? ack0 : ack1;
  endfunction
  function automatic logic [15:0] get_ra(input int n);
    return (n == 0) ? ra0 : ra1;
  endfunction
  function automatic logic [15:0] get_rb(input int n);
    return (n == 0) ? rb0 : rb1;
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_ra[0] = '0; exp_ra[1] = '0;
    exp_rb[0] = '0; exp_rb[1] = '0;
    last_served = 0;
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    req = '0; rd = '0; wr = '0; init_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      aa[i] = '0; ba[i] = '0; da[i] = '0; wd[i] = '0;
    end
    tick();
    tick();
    model_reset();
  endtask

  // One access by a single requester; checks latency, bus code, data, ack.
  task automatic do_txn(input int n, input logic r, input logic w,
                        input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                        input logic [15:0] data, input string tag);
    logic [15:0] ea, eb;
    logic [1:0]  seen_rw;
    int          cyc;
    bit          got, other;
    ea = r ? exp_mem[a] : exp_ra[n];
    eb = r ? exp_mem[b] : exp_rb[n];
    exp_ra[n] = ea;
    exp_rb[n] = eb;
    if (w) exp_mem[d] = data;
    last_served = n;

    req[n] = 1'b1; rd[n] = r; wr[n] = w;
    aa[n] = a; ba[n] = b; da[n] = d; wd[n] = data;
    seen_rw = 2'bxx; cyc = 0; got = 0; other = 0;
    while (!got && cyc < 12) begin
      tick();
      cyc++;
      if (rf_en) seen_rw = rf_rw;
      if (get_ack(1 - n) !== 1'b0) other = 1;
      if (get_ack(n) === 1'b1) got = 1;
    end
    req[n] = 1'b0;

    // Edge 1 samples req, edge 3 returns ack: two cycles after sampling
    n_total++;
    if (!got || cyc != 3) $display("FAIL %s latency: ack seen=%0d at edge %0d, need ack at edge 3", tag, got, cyc);
    else n_pass++;
    n_total++;
    if (seen_rw !== {r, w}) $display("FAIL %s rf_rw: got %b need %b", tag, seen_rw, {r, w});
    else n_pass++;
    n_total++;
    if (get_ra(n) !== ea || get_rb(n) !== eb)
      $display("FAIL %s data: ra=%h rb=%h need ra=%h rb=%h", tag, get_ra(n), get_rb(n), ea, eb);
    else n_pass++;
    n_total++;
    if (other) $display("FAIL %s other ack: non-requester ack went high", tag);
    else n_pass++;
    tick();
    n_total++;
    if (get_ack(n) !== 1'b0) $display("FAIL %s ack pulse: ack still %b one cycle later, need 0", tag, get_ack(n));
    else n_pass++;
  endtask

  task automatic test_reset();
    hold_reset();
    n_total++;
    if (busy !== 1'b0 || rf_en !== 1'b0) $display("FAIL reset busy/rf_en: busy=%b rf_en=%b need 0/0", busy, rf_en);
    else n_pass++;
    n_total++;
    if ({ack0, ack1} !== 2'b00) $display("FAIL reset ack: got %b need 00", {ack0, ack1});
    else n_pass++;
    n_total++;
    if ({rf_rw, rf_da, rf_aa, rf_ba, rf_d} !== '0)
      $display("FAIL reset bus: rw=%b da=%h aa=%h ba=%h d=%h need all 0", rf_rw, rf_da, rf_aa, rf_ba, rf_d);
    else n_pass++;
    n_total++;
    if ({ra0, rb0, ra1, rb1} !== '0) $display("FAIL reset rdata: %h %h %h %h need all 0", ra0, rb0, ra1, rb1);
    else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    do_txn(0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd3, 16'hBEEF, "wr_r3");
    do_txn(0, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0, 16'h0000, "rd_r3");
  endtask

  task automatic test_round_robin();
    int  acks, cyc, who, exp_who;
    bit  both;
    hold_reset();
    reset = 1'b0;
    for (int n = 0; n < 2; n++) begin
      req[n] = 1'b1; rd[n] = 1'b1; wr[n] = 1'b0;
      aa[n] = 4'($urandom); ba[n] = 4'($urandom);
    end
    acks = 0; cyc = 0; both = 0;
    while (acks < 4 && cyc < 60) begin
      tick();
      cyc++;
      if (ack0 && ack1) begin
        both = 1;
      end else if (ack0 || ack1) begin
        who = ack1 ? 1 : 0;
        exp_who = 1 - last_served;
        n_total++;
        if (who != exp_who) $display("FAIL rr order #%0d: served %0d need %0d", acks, who, exp_who);
        else n_pass++;
        n_total++;
        if (get_ra(who) !== exp_mem[aa[who]] || get_rb(who) !== exp_mem[ba[who]])
          $display("FAIL rr data #%0d: ra=%h rb=%h need %h %h", acks, get_ra(who), get_rb(who), exp_mem[aa[who]], exp_mem[ba[who]]);
        else n_pass++;
        exp_ra[who] = exp_mem[aa[who]];
        exp_rb[who] = exp_mem[ba[who]];
        last_served = who;
        acks++;
        aa[who] = 4'($urandom); ba[who] = 4'($urandom);
      end
    end
    req = '0;
    n_total++;
    if (acks != 4) $display("FAIL rr count: %0d acks in %0d cycles, need 4", acks, cyc);
    else n_pass++;
    n_total++;
    if (both) $display("FAIL rr exclusive: ack0 and ack1 high together, need never");
    else n_pass++;
    tick();
  endtask

  task automatic test_init();
    int cnt;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      n_total++;
      if (rf_en !== 1'b1 || rf_rw !== 2'b01 || rf_da !== cnt[3:0] || rf_d !== INIT_VAL)
        $display("FAIL init cycle %0d: en=%b rw=%b da=%h d=%h need 1/01/%h/%h", cnt, rf_en, rf_rw, rf_da, rf_d, cnt[3:0], INIT_VAL);
      else n_pass++;
      cnt++;
      tick();
    end
    n_total++;
    if (cnt != 16) $display("FAIL init length: busy for %0d cycles, need 16", cnt);
    else n_pass++;
    for (int i = 0; i < 16; i++) exp_mem[i] = INIT_VAL;
    do_txn(1, 1'b1, 1'b0, 4'd15, 4'd0, 4'd0, 16'h0000, "rd_r15_after_init");
  endtask

  task automatic test_rw_same();
    do_txn(0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd5, 16'h0001, "wr_r5");
    do_txn(0, 1'b1, 1'b1, 4'd5, 4'd5, 4'd5, 16'h0002, "rw_r5");
    do_txn(1, 1'b1, 1'b0, 4'd5, 4'd2, 4'd0, 16'h0000, "rd_r5");
  endtask

  task automatic test_nop();
    do_txn(1, 1'b0, 1'b0, 4'd7, 4'd8, 4'd9, 16'h1234, "nop");
  endtask

  task automatic test_init_during_cmd();
    int init_cycles, cyc;
    bit got1;
    req[0] = 1'b1; rd[0] = 1'b0; wr[0] = 1'b1;
    aa[0] = '0; ba[0] = '0; da[0] = 4'd11; wd[0] = 16'h7777;
    tick();                       // req0 sampled, access in CMD
    init_start = 1'b1;
    req[1] = 1'b1; rd[1] = 1'b1; wr[1] = 1'b0; aa[1] = 4'd9; ba[1] = 4'd11;
    tick();                       // RESP
    init_start = 1'b0;
    tick();                       // ack0 visible
    n_total++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0) $display("FAIL icmd ack0: ack0=%b ack1=%b need 1/0", ack0, ack1);
    else n_pass++;
    req[0] = 1'b0;
    for (int i = 0; i < 16; i++) exp_mem[i] = INIT_VAL;   // init overwrites r11 too
    init_cycles = 0; cyc = 0; got1 = 0;
    while (!got1 && cyc < 40) begin
      tick();
      cyc++;
      if (rf_en === 1'b1 && rf_rw === 2'b01 && rf_d === INIT_VAL) init_cycles++;
      if (ack1 === 1'b1) got1 = 1;
    end
    req[1] = 1'b0;
    n_total++;
    if (!got1 || init_cycles != 16)
      $display("FAIL icmd order: ack1=%0d after %0d init writes, need ack1 after 16", got1, init_cycles);
    else n_pass++;
    n_total++;
    if (ra1 !== INIT_VAL || rb1 !== INIT_VAL) $display("FAIL icmd data: ra1=%h rb1=%h need %h", ra1, rb1, INIT_VAL);
    else n_pass++;
    exp_ra[1] = INIT_VAL; exp_rb[1] = INIT_VAL;
    last_served = 1;
    tick();
  endtask

  task automatic test_reset_in_init();
    bit quiet;
    init_start = 1'b1;
    tick();                       // INIT cycle 0
    init_start = 1'b0;
    repeat (7) tick();            // INIT cycle 7
    n_total++;
    if (rf_da !== 4'd7 || busy !== 1'b1) $display("FAIL rinit cycle7: da=%h busy=%b need 7/1", rf_da, busy);
    else n_pass++;
    reset = 1'b1;
    tick();
    n_total++;
    if (rf_en !== 1'b0 || busy !== 1'b0 || {ack0, ack1} !== 2'b00)
      $display("FAIL rinit abort: rf_en=%b busy=%b ack=%b need 0/0/00", rf_en, busy, {ack0, ack1});
    else n_pass++;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) exp_mem[i] = INIT_VAL;    // writes up to cycle 7 landed
    quiet = 1;
    repeat (20) begin
      tick();
      if (rf_en !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) quiet = 0;
    end
    n_total++;
    if (!quiet) $display("FAIL rinit quiet: bus or ack activity after reset, need none");
    else n_pass++;
    do_txn(0, 1'b1, 1'b0, 4'd7, 4'd8, 4'd0, 16'h0000, "rd_after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      do_txn(int'($urandom_range(0, 1)), 1'($urandom), 1'($urandom),
             4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    model_reset();
    test_reset();
    test_write_read();
    test_round_robin();
    test_init();
    test_rw_same();
    test_nop();
    test_init_during_cmd();
    test_reset_in_init();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
